// File: rtl/acc_stream_arbiter.sv
// Packet-level round-robin merge of NUM_ACCS AXI-Stream inputs into one output
// through a one-deep register slice; tid is carried through untouched.
module acc_stream_arbiter #(
  parameter int NUM_ACCS    = 4,
  parameter int ACCID_WIDTH = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int DEST_WIDTH  = 3
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [NUM_ACCS*DATA_WIDTH-1:0]    in_tdata,
  input  logic [NUM_ACCS*DEST_WIDTH-1:0]    in_tdest,
  input  logic [NUM_ACCS*ACCID_WIDTH-1:0]   in_tid,
  input  logic [NUM_ACCS-1:0]               in_tlast,
  input  logic [NUM_ACCS-1:0]               in_tvalid,
  output logic [NUM_ACCS-1:0]               in_tready,
  output logic [DATA_WIDTH-1:0]             out_tdata,
  output logic [DEST_WIDTH-1:0]             out_tdest,
  output logic [ACCID_WIDTH-1:0]            out_tid,
  output logic                              out_tlast,
  output logic                              out_tvalid,
  input  logic                              out_tready,
  output logic [ACCID_WIDTH-1:0]            grant_idx
);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t                  state_q, state_d;
  logic [ACCID_WIDTH-1:0]  grant_q, grant_d;
  logic [ACCID_WIDTH-1:0]  last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DEST_WIDTH-1:0]   dest_q, dest_d;
  logic [ACCID_WIDTH-1:0]  tid_q, tid_d;
  logic                    last_q, last_d;
  logic                    valid_q, valid_d;

  logic                    sel_valid, sel_last;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [DEST_WIDTH-1:0]   sel_dest;
  logic [ACCID_WIDTH-1:0]  sel_tid;
  logic                    slot_ready, accept;
  logic                    found_hi, found_lo;
  logic [ACCID_WIDTH-1:0]  idx_hi, idx_lo, pick_idx;

  // Fields of the currently granted input.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_dest  = '0;
    sel_tid   = '0;
    for (int i = 0; i < NUM_ACCS; i++) begin
      if (grant_q == ACCID_WIDTH'(i)) begin
        sel_valid = in_tvalid[i];
        sel_last  = in_tlast[i];
        sel_data  = in_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_dest  = in_tdest[i*DEST_WIDTH +: DEST_WIDTH];
        sel_tid   = in_tid[i*ACCID_WIDTH +: ACCID_WIDTH];
      end
    end
  end

  assign slot_ready = (state_q == S_LOCKED) && (!valid_q || out_tready);
  assign accept     = slot_ready && sel_valid;

  always_comb begin
    in_tready = '0;
    for (int i = 0; i < NUM_ACCS; i++) begin
      in_tready[i] = slot_ready && (grant_q == ACCID_WIDTH'(i));
    end
  end

  // Rotating priority: lowest requester above last_grant wins, else wrap to the lowest overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int j = NUM_ACCS - 1; j >= 0; j--) begin
      if (in_tvalid[j]) begin
        if (ACCID_WIDTH'(j) > last_grant_q) begin
          found_hi = 1'b1;
          idx_hi   = ACCID_WIDTH'(j);
        end else begin
          found_lo = 1'b1;
          idx_lo   = ACCID_WIDTH'(j);
        end
      end
    end
    pick_idx = found_hi ? idx_hi : idx_lo;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      S_IDLE: begin
        if (found_hi || found_lo) begin
          grant_d = pick_idx;
          state_d = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (accept && sel_last) begin
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    dest_d  = dest_q;
    tid_d   = tid_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (accept) begin
      data_d  = sel_data;
      dest_d  = sel_dest;
      tid_d   = sel_tid;
      last_d  = sel_last;
      valid_d = 1'b1;
    end else if (valid_q && out_tready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= ACCID_WIDTH'(NUM_ACCS - 1);
      data_q       <= '0;
      dest_q       <= '0;
      tid_q        <= '0;
      last_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      dest_q       <= dest_d;
      tid_q        <= tid_d;
      last_q       <= last_d;
      valid_q      <= valid_d;
    end
  end

  assign out_tdata  = data_q;
  assign out_tdest  = dest_q;
  assign out_tid    = tid_q;
  assign out_tlast  = last_q;
  assign out_tvalid = valid_q;
  assign grant_idx  = grant_q;

endmodule

// File: tb/tb_acc_stream_arbiter.sv
// Bench for acc_stream_arbiter: cycle vector table, directed corner sequences,
// and a randomized run scored against a packet-level round-robin model.
module tb_acc_stream_arbiter;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 64;
  localparam int SW = 3;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [N*DW-1:0] in_tdata = '0;
  logic [N*SW-1:0] in_tdest = '0;
  logic [N*AW-1:0] in_tid = '0;
  logic [N-1:0]    in_tlast = '0;
  logic [N-1:0]    in_tvalid = '0;
  logic [N-1:0]    in_tready;
  logic [DW-1:0]   out_tdata;
  logic [SW-1:0]   out_tdest;
  logic [AW-1:0]   out_tid;
  logic            out_tlast;
  logic            out_tvalid;
  logic            out_tready = 1'b0;
  logic [AW-1:0]   grant_idx;

  int total = 0;
  int bad = 0;

  acc_stream_arbiter #(.NUM_ACCS(N), .ACCID_WIDTH(AW), .DATA_WIDTH(DW), .DEST_WIDTH(SW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_tdata(in_tdata), .in_tdest(in_tdest), .in_tid(in_tid),
    .in_tlast(in_tlast), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tdest(out_tdest), .out_tid(out_tid),
    .out_tlast(out_tlast), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .grant_idx(grant_idx)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge aclk);
    aresetn = 1'b0;
    in_tvalid = '0;
    in_tlast = '0;
    out_tready = 1'b1;
    #3;
    aresetn = 1'b1;
  endtask

  // Table mode: input i carries data 0xA4+i, dest i+1, tid i.
  task automatic set_fixed_fields();
    for (int i = 0; i < N; i++) begin
      in_tdata[i*DW +: DW] = 64'hA4 + 64'(i);
      in_tdest[i*SW +: SW] = SW'(i + 1);
      in_tid[i*AW +: AW]   = AW'(i);
    end
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] vld;
    logic [3:0] lst;
    logic       ord;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [3:0] exp_tid;
    logic       exp_last;
  } vec_t;

  typedef struct packed {
    logic [63:0] d;
    logic [2:0]  dst;
    logic [3:0]  id;
    logic        l;
  } beat_t;

  vec_t tbl [23];

  // Randomized-run storage
  logic [63:0] bd    [N][32];
  logic [2:0]  bdst  [N][32];
  logic [3:0]  btid  [N][32];
  bit          blast [N][32];
  bit          bfirst[N][32];
  int          bn[N];
  int          npk[N];
  int          ptr[N];
  bit          vld[N];
  beat_t       expq[$];

  initial begin
    // single beat on in1
    tbl[0]  = '{1, 4'b0010, 4'b0010, 1, 4'b0000, 0, 4'd0, 0};
    tbl[1]  = '{0, 4'b0010, 4'b0010, 1, 4'b0010, 0, 4'd0, 0};
    tbl[2]  = '{0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 4'd1, 1};
    tbl[3]  = '{0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 4'd0, 0};
    // round robin between in0 and in2
    tbl[4]  = '{1, 4'b0101, 4'b0101, 1, 4'b0000, 0, 4'd0, 0};
    tbl[5]  = '{0, 4'b0101, 4'b0101, 1, 4'b0001, 0, 4'd0, 0};
    tbl[6]  = '{0, 4'b0101, 4'b0101, 1, 4'b0000, 1, 4'd0, 1};
    tbl[7]  = '{0, 4'b0101, 4'b0101, 1, 4'b0100, 0, 4'd0, 0};
    tbl[8]  = '{0, 4'b0101, 4'b0101, 1, 4'b0000, 1, 4'd2, 1};
    tbl[9]  = '{0, 4'b0101, 4'b0101, 1, 4'b0001, 0, 4'd0, 0};
    tbl[10] = '{0, 4'b0101, 4'b0101, 1, 4'b0000, 1, 4'd0, 1};
    tbl[11] = '{0, 4'b0101, 4'b0101, 1, 4'b0100, 0, 4'd0, 0};
    tbl[12] = '{0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 4'd2, 1};
    tbl[13] = '{0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 4'd0, 0};
    // packet lock: in0 4 beats, in3 arrives at beat 2
    tbl[14] = '{1, 4'b0001, 4'b0000, 1, 4'b0000, 0, 4'd0, 0};
    tbl[15] = '{0, 4'b0001, 4'b0000, 1, 4'b0001, 0, 4'd0, 0};
    tbl[16] = '{0, 4'b1001, 4'b1000, 1, 4'b0001, 1, 4'd0, 0};
    tbl[17] = '{0, 4'b1001, 4'b1000, 1, 4'b0001, 1, 4'd0, 0};
    tbl[18] = '{0, 4'b1001, 4'b1001, 1, 4'b0001, 1, 4'd0, 0};
    tbl[19] = '{0, 4'b1000, 4'b1000, 1, 4'b0000, 1, 4'd0, 1};
    tbl[20] = '{0, 4'b1000, 4'b1000, 1, 4'b1000, 0, 4'd0, 0};
    tbl[21] = '{0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 4'd3, 1};
    tbl[22] = '{0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 4'd0, 0};

    // reset state
    #2;
    chk("reset_ovalid", 80'(out_tvalid), 80'(0));
    chk("reset_ready", 80'(in_tready), 80'(0));
    chk("reset_data", 80'({out_tdata, out_tdest, out_tid, out_tlast}), 80'(0));
    chk("reset_grant", 80'(grant_idx), 80'(0));

    set_fixed_fields();
    for (int k = 0; k < 23; k++) begin
      if (tbl[k].rst) reset_dut();
      @(negedge aclk);
      in_tvalid  = tbl[k].vld;
      in_tlast   = tbl[k].lst;
      out_tready = tbl[k].ord;
      #1;
      chk($sformatf("vec%0d_ready", k), 80'(in_tready), 80'(tbl[k].exp_rdy));
      chk($sformatf("vec%0d_ovalid", k), 80'(out_tvalid), 80'(tbl[k].exp_ov));
      if (tbl[k].exp_ov) begin
        chk($sformatf("vec%0d_beat", k), 80'({out_tdata, out_tdest, out_tid, out_tlast}),
            80'({64'hA4 + 64'(tbl[k].exp_tid), SW'(tbl[k].exp_tid + 1), tbl[k].exp_tid, tbl[k].exp_last}));
      end
    end

    // backpressure on in1: D0 stalls for 5 cycles, then D1, D2 follow back to back
    reset_dut();
    @(negedge aclk);
    in_tvalid = 4'b0010; in_tlast = 4'b0000; in_tdata[1*DW +: DW] = 64'hD0; out_tready = 1'b1;
    #1; chk("bp_idle_ready", 80'(in_tready), 80'(0));
    @(negedge aclk);
    #1; chk("bp_lock_ready", 80'(in_tready), 80'(4'b0010));
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      in_tdata[1*DW +: DW] = 64'hD1; out_tready = 1'b0;
      #1;
      chk("bp_hold_data", 80'({out_tvalid, out_tdata}), 80'({1'b1, 64'hD0}));
      chk("bp_hold_ready", 80'(in_tready), 80'(0));
    end
    @(negedge aclk);
    out_tready = 1'b1;
    #1;
    chk("bp_release_data", 80'(out_tdata), 80'(64'hD0));
    chk("bp_release_ready", 80'(in_tready), 80'(4'b0010));
    @(negedge aclk);
    in_tdata[1*DW +: DW] = 64'hD2; in_tlast = 4'b0010;
    #1;
    chk("bp_d1", 80'({out_tvalid, out_tdata, out_tlast}), 80'({1'b1, 64'hD1, 1'b0}));
    @(negedge aclk);
    in_tvalid = '0; in_tlast = '0;
    #1;
    chk("bp_d2", 80'({out_tvalid, out_tdata, out_tlast}), 80'({1'b1, 64'hD2, 1'b1}));
    @(negedge aclk);
    #1;
    chk("bp_empty", 80'(out_tvalid), 80'(0));

    // throughput: 8-beat packet on in2
    begin
      int k;
      int outn;
      k = 0;
      outn = 0;
      reset_dut();
      for (int c = 0; c < 12; c++) begin
        @(negedge aclk);
        in_tvalid = (k < 8) ? 4'b0100 : 4'b0000;
        in_tlast  = (k == 7) ? 4'b0100 : 4'b0000;
        in_tdata[2*DW +: DW] = 64'h1000 + 64'(k);
        out_tready = 1'b1;
        #1;
        if (out_tvalid) begin
          chk("tput_data", 80'(out_tdata), 80'(64'h1000 + 64'(outn)));
          chk("tput_cycle", 80'(c), 80'(2 + outn));
          outn++;
        end
        if (in_tvalid[2] && in_tready[2]) k++;
      end
      chk("tput_count", 80'(outn), 80'(8));
    end

    // async reset mid-packet, then input 0 must win again
    reset_dut();
    set_fixed_fields();
    @(negedge aclk); in_tvalid = 4'b0010; in_tlast = 4'b0010;
    @(negedge aclk);
    @(negedge aclk); in_tvalid = 4'b0100; in_tlast = 4'b0000;
    @(negedge aclk);
    @(negedge aclk);
    #1;
    chk("ar_pre_ready", 80'(in_tready), 80'(4'b0100));
    chk("ar_pre_ovalid", 80'(out_tvalid), 80'(1));
    #2;
    aresetn = 1'b0;
    #1;
    chk("ar_ovalid", 80'(out_tvalid), 80'(0));
    chk("ar_ready", 80'(in_tready), 80'(0));
    in_tvalid = 4'b0101; in_tlast = 4'b0101;
    aresetn = 1'b1;
    @(negedge aclk);
    #1;
    chk("ar_after_ready", 80'(in_tready), 80'(4'b0001));
    chk("ar_after_grant", 80'(grant_idx), 80'(0));

    // randomized run against packet-level round-robin model
    begin
      int rem[N];
      int mp[N];
      int lastg;
      int left;
      int cyc;
      bit hold_prev;
      beat_t held;
      beat_t got;
      beat_t e;
      for (int i = 0; i < N; i++) begin
        bn[i] = 0;
        npk[i] = $urandom_range(3, 6);
        for (int p = 0; p < npk[i]; p++) begin
          int len;
          len = $urandom_range(1, 5);
          for (int b = 0; b < len; b++) begin
            bd[i][bn[i]]     = {$urandom(), $urandom()};
            bdst[i][bn[i]]   = SW'($urandom());
            btid[i][bn[i]]   = AW'($urandom());
            bfirst[i][bn[i]] = (b == 0);
            blast[i][bn[i]]  = (b == len - 1);
            bn[i]++;
          end
        end
      end
      // expected packet order: every pending input is requesting whenever the arbiter is idle
      lastg = N - 1;
      left = 0;
      for (int i = 0; i < N; i++) begin rem[i] = npk[i]; mp[i] = 0; left += npk[i]; end
      while (left > 0) begin
        for (int off = 1; off <= N; off++) begin
          int idx;
          idx = (lastg + off) % N;
          if (rem[idx] > 0) begin
            bit done;
            done = 0;
            while (!done) begin
              expq.push_back('{bd[idx][mp[idx]], bdst[idx][mp[idx]], btid[idx][mp[idx]], blast[idx][mp[idx]]});
              done = blast[idx][mp[idx]];
              mp[idx]++;
            end
            rem[idx]--;
            left--;
            lastg = idx;
            break;
          end
        end
      end

      reset_dut();
      for (int i = 0; i < N; i++) begin ptr[i] = 0; vld[i] = 0; end
      cyc = 0;
      hold_prev = 0;
      held = '0;
      while (expq.size() > 0 && cyc < 4000) begin
        @(negedge aclk);
        for (int i = 0; i < N; i++) begin
          if (ptr[i] < bn[i]) begin
            if (!vld[i]) vld[i] = bfirst[i][ptr[i]] ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_tdata[i*DW +: DW] = bd[i][ptr[i]];
            in_tdest[i*SW +: SW] = bdst[i][ptr[i]];
            in_tid[i*AW +: AW]   = btid[i][ptr[i]];
            in_tlast[i]          = blast[i][ptr[i]];
          end else begin
            vld[i] = 0;
            in_tlast[i] = 1'b0;
          end
          in_tvalid[i] = vld[i];
        end
        out_tready = ($urandom_range(0, 3) != 0);
        #1;
        got = '{out_tdata, out_tdest, out_tid, out_tlast};
        if (hold_prev) chk("rand_stable", 80'({out_tvalid, got}), 80'({1'b1, held}));
        chk("rand_onehot_ready", 80'($countones(in_tready) <= 1), 80'(1));
        if (out_tvalid && out_tready) begin
          e = expq.pop_front();
          chk("rand_beat", 80'(got), 80'(e));
        end
        for (int i = 0; i < N; i++) begin
          if (vld[i] && in_tready[i]) begin
            ptr[i]++;
            vld[i] = 0;
          end
        end
        hold_prev = out_tvalid && !out_tready;
        held = got;
        cyc++;
      end
      chk("rand_drain", 80'(expq.size()), 80'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_stream_arbiter.md
Name: acc_stream_arbiter

Overview:
- Merges the AXI-Stream output channels of NUM_ACCS accelerator wrappers into one stream towards the runtime interconnect.
- Sits directly downstream of each accelerator's handshake-to-stream adapter.
- Arbitrates round-robin per packet: a granted input holds the output until its tlast beat is accepted.
- Output passes through a one-deep register slice; the accelerator ID (tid) travels with each beat.

Parameters:
- NUM_ACCS, 4, number of input streams (2..16).
- ACCID_WIDTH, 4, width of tid; must satisfy 2^ACCID_WIDTH >= NUM_ACCS.
- DATA_WIDTH, 64, tdata width.
- DEST_WIDTH, 3, tdest width.

Ports:
- aclk  input  1  clock.
- aresetn  input  1  asynchronous active-low reset.
- in_tdata  input  NUM_ACCS*DATA_WIDTH  input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_tdest  input  NUM_ACCS*DEST_WIDTH  packed per input.
- in_tid  input  NUM_ACCS*ACCID_WIDTH  packed per input.
- in_tlast  input  NUM_ACCS  per input.
- in_tvalid  input  NUM_ACCS  per input.
- in_tready  output  NUM_ACCS  per input.
- out_tdata  output  DATA_WIDTH  merged data.
- out_tdest  output  DEST_WIDTH  merged dest.
- out_tid  output  ACCID_WIDTH  merged id.
- out_tlast  output  1  merged last.
- out_tvalid  output  1  merged valid.
- out_tready  input  1  downstream ready.
- grant_idx  output  ACCID_WIDTH  index of the currently locked input (debug).

Behaviour:
- Reset:
  - Asserting aresetn low asynchronously clears state to IDLE.
  - out_tvalid=0, out_tdata/tdest/tid/tlast=0, in_tready=0, grant_idx=0.
  - last_grant=NUM_ACCS-1, so input 0 has first priority.
- States:
  - IDLE: if any in_tvalid is set, choose the first requesting index scanning last_grant+1, last_grant+2, ... modulo NUM_ACCS. Register it as grant and go to LOCKED. No beat is accepted in the arbitration cycle, so there is a 1-cycle bubble per packet. If no input is valid, stay in IDLE.
  - LOCKED: in_tready[grant] = (!out_tvalid || out_tready); all other in_tready bits are 0. Every other in_tready bit is also 0 in IDLE.
  - When a beat with tlast=1 is accepted on the granted input: last_grant<=grant, next state IDLE.
- Slice:
  - On an accepted input beat, the slice loads tdata/tdest/tid/tlast and sets out_tvalid=1 on the next edge (latency 1 cycle).
  - When out_tvalid && out_tready with no new beat loaded, out_tvalid<=0.
  - Simultaneous load and drain: the slice is overwritten and out_tvalid stays 1, giving 1 beat/cycle sustained.
  - Output fields remain stable while out_tvalid && !out_tready.
- tid is forwarded from the input unchanged; the block never substitutes the port index.
- A granted input dropping tvalid mid-packet keeps the lock; no other input is served until tlast.
- Inputs that are not granted are never acked, even if valid.
- Zero-length packets do not exist: a single beat with tlast=1 is a complete packet.
- Reset mid-packet: the lock is abandoned and the partial packet is lost downstream. This is acceptable because the whole accelerator domain resets together.
- grant_idx holds the last registered grant (it updates on entry to LOCKED) and is valid while in LOCKED.

Test Plan:
- Single beat, one input: in1 sends tdata=0xA5, tdest=2, tid=1, tlast=1, out_tready=1.
  -> One cycle in IDLE, then in_tready[1]=1.
  -> Next cycle out_tvalid=1 with 0xA5/2/1/1, then out_tvalid=0.
- Round-robin fairness: inputs 0 and 2 both continuously send 1-beat packets.
  -> Output tid sequence is 0,2,0,2,...
  -> Never two consecutive packets from one input while the other is waiting.
- Packet lock: in0 sends 4 beats (tlast on beat 4); in3 becomes valid at beat 2.
  -> All 4 beats of in0 are output contiguously before any in3 beat.
  -> in_tready[3]=0 throughout that packet.
- Backpressure: out_tready held 0 for 5 cycles during a 3-beat packet D0,D1,D2.
  -> out_tdata holds D0 for all 5 cycles; in_tready[grant]=0.
  -> After release, D1 and D2 follow on consecutive cycles with no loss or duplication.
- Throughput: 8-beat packet with out_tready=1.
  -> 8 output beats on 8 consecutive cycles after the 1-cycle arbitration bubble.
- Async reset: aresetn asserted mid-packet, between clock edges.
  -> out_tvalid and in_tready go 0 immediately.
  -> After release, input 0 has first priority again.
